// File: rtl/nios_ii_system_irq_pkg.sv
// Shared constants and helpers for the nios_ii_system interrupt aggregator.
package nios_ii_system_irq_pkg;

    localparam logic [2:0] ADDR_PENDING  = 3'd0;
    localparam logic [2:0] ADDR_MASK     = 3'd1;
    localparam logic [2:0] ADDR_EDGE_SEL = 3'd2;
    localparam logic [2:0] ADDR_RAW      = 3'd3;
    localparam logic [2:0] ADDR_ACTIVE   = 3'd4;
    localparam logic [2:0] ADDR_VECTOR   = 3'd5;
    localparam logic [2:0] ADDR_FORCE    = 3'd6;
    localparam logic [2:0] ADDR_EVCOUNT  = 3'd7;

    localparam int EVCOUNT_W = 16;
    localparam logic [EVCOUNT_W-1:0] EVCOUNT_MAX = '1;

    // Lowest set index wins; returns 0 when nothing is set.
    function automatic logic [3:0] prio_enc(input logic [15:0] v);
        prio_enc = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) prio_enc = 4'(i);
        end
    endfunction

endpackage

// File: rtl/nios_ii_system_irq_sync.sv
// Two-flop synchroniser per interrupt source plus a history
// flop used for rising-edge detection.
module nios_ii_system_irq_sync #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] d,
    output logic [NUM_IRQ-1:0] s2,
    output logic [NUM_IRQ-1:0] rise
);

    logic [NUM_IRQ-1:0] s1;
    logic [NUM_IRQ-1:0] prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= '0;
            s2   <= '0;
            prev <= '0;
        end else begin
            s1   <= d;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign rise = s2 & ~prev;

endmodule

// File: rtl/nios_ii_system_irq_aggregator.sv
// Avalon-MM interrupt aggregator: per-source level/edge capture,
// mask, W1C pending, event counter and a priority-encoded vector.
module nios_ii_system_irq_aggregator
    import nios_ii_system_irq_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq,
    output logic [ID_W-1:0]    irq_id,
    output logic               irq_valid
);

    logic [NUM_IRQ-1:0]   s2;
    logic [NUM_IRQ-1:0]   rise;
    logic [NUM_IRQ-1:0]   pending;
    logic [NUM_IRQ-1:0]   mask;
    logic [NUM_IRQ-1:0]   edge_sel;
    logic [EVCOUNT_W-1:0] evcount;

    logic                 wr;
    logic                 wr_pend;
    logic                 wr_mask;
    logic                 wr_edge;
    logic                 wr_force;
    logic                 wr_evc;
    logic [NUM_IRQ-1:0]   wdn;
    logic [NUM_IRQ-1:0]   force_bits;
    logic [NUM_IRQ-1:0]   clr_bits;
    logic [NUM_IRQ-1:0]   set_bits;
    logic [NUM_IRQ-1:0]   pend_d;
    logic [NUM_IRQ-1:0]   active;
    logic [15:0]          vector;
    logic [15:0]          rd_d;
    logic [3:0]           id4;

    nios_ii_system_irq_sync #(
        .NUM_IRQ(NUM_IRQ)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (irq_in),
        .s2   (s2),
        .rise (rise)
    );

    assign wr       = chipselect && !write_n;
    assign wr_pend  = wr && (address == ADDR_PENDING);
    assign wr_mask  = wr && (address == ADDR_MASK);
    assign wr_edge  = wr && (address == ADDR_EDGE_SEL);
    assign wr_force = wr && (address == ADDR_FORCE);
    assign wr_evc   = wr && (address == ADDR_EVCOUNT);
    assign wdn      = writedata[NUM_IRQ-1:0];

    always_comb begin
        force_bits = wr_force ? wdn : '0;
        clr_bits   = wr_pend ? wdn : '0;
        // Set has priority over a same-cycle W1C.
        set_bits   = edge_sel & (rise | force_bits);
        pend_d     = (~edge_sel & s2) | set_bits
                   | (edge_sel & pending & ~clr_bits);
        active     = pending & mask;
        id4        = prio_enc(16'(active));
    end

    always_comb begin
        vector           = '0;
        vector[15]       = irq_valid;
        vector[ID_W-1:0] = irq_id;
    end

    always_comb begin
        rd_d = '0;
        unique case (address)
            ADDR_PENDING:  rd_d = 16'(pending);
            ADDR_MASK:     rd_d = 16'(mask);
            ADDR_EDGE_SEL: rd_d = 16'(edge_sel);
            ADDR_RAW:      rd_d = 16'(s2);
            ADDR_ACTIVE:   rd_d = 16'(active);
            ADDR_VECTOR:   rd_d = vector;
            ADDR_FORCE:    rd_d = '0;
            ADDR_EVCOUNT:  rd_d = evcount;
            default:       rd_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending   <= '0;
            mask      <= '0;
            edge_sel  <= '0;
            evcount   <= '0;
            readdata  <= '0;
            irq       <= 1'b0;
            irq_valid <= 1'b0;
            irq_id    <= '0;
        end else begin
            pending   <= pend_d;
            readdata  <= rd_d;
            irq       <= |active;
            irq_valid <= |active;
            irq_id    <= ID_W'(id4);
            if (wr_mask) mask <= wdn;
            if (wr_edge) edge_sel <= wdn;
            if (wr_evc) begin
                evcount <= '0;
            end else if (|set_bits && evcount != EVCOUNT_MAX) begin
                evcount <= evcount + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nios_ii_system_irq_aggregator.sv
// Directed plus randomized checks of the interrupt aggregator
// against a per-bit behavioural model.
module tb_nios_ii_system_irq_aggregator;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [15:0]  writedata;
    logic [15:0]  readdata;
    logic [N-1:0] irq_in;
    logic         irq;
    logic [3:0]   irq_id;
    logic         irq_valid;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b1;

    bit [15:0] m_s1, m_s2, m_prev, m_pend, m_mask, m_edge;
    bit [15:0] m_evc, m_rd;
    bit        m_irq;
    bit [3:0]  m_id;

    always #5 clk = ~clk;

    nios_ii_system_irq_aggregator #(
        .NUM_IRQ(N),
        .ID_W   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .irq_in    (irq_in),
        .irq       (irq),
        .irq_id    (irq_id),
        .irq_valid (irq_valid)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit [3:0] lowest(input bit [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return 4'(i);
        return 4'd0;
    endfunction

    // One clock edge of the register-level behaviour, from old state.
    task automatic model_edge();
        bit        wr;
        bit        any_set;
        bit        rise_i, set_i;
        bit [15:0] npend, act, nevc;
        wr      = chipselect && !write_n;
        any_set = 1'b0;
        act     = m_pend & m_mask;
        npend   = m_pend;
        nevc    = m_evc;
        for (int i = 0; i < N; i++) begin
            if (m_edge[i]) begin
                rise_i = m_s2[i] && !m_prev[i];
                set_i  = rise_i || (wr && address == 3'd6 && writedata[i]);
                if (set_i) begin
                    npend[i] = 1'b1;
                    any_set  = 1'b1;
                end else if (wr && address == 3'd0 && writedata[i]) begin
                    npend[i] = 1'b0;
                end
            end else begin
                npend[i] = m_s2[i];
            end
        end
        if (wr && address == 3'd7) nevc = 0;
        else if (any_set && m_evc < 16'hFFFF) nevc = m_evc + 1;
        case (address)
            3'd0: m_rd = m_pend;
            3'd1: m_rd = m_mask;
            3'd2: m_rd = m_edge;
            3'd3: m_rd = m_s2;
            3'd4: m_rd = act;
            3'd5: m_rd = {m_irq, 11'd0, m_id};
            3'd6: m_rd = 16'd0;
            default: m_rd = m_evc;
        endcase
        m_irq  = act != 0;
        m_id   = lowest(act);
        m_pend = npend;
        m_evc  = nevc;
        if (wr && address == 3'd1) m_mask = writedata & 16'h00FF;
        if (wr && address == 3'd2) m_edge = writedata & 16'h00FF;
        m_prev = m_s2;
        m_s2   = m_s1;
        m_s1   = 16'(irq_in);
        if (reset) begin
            {m_s1, m_s2, m_prev, m_pend} = '0;
            {m_mask, m_edge, m_evc, m_rd} = '0;
            m_irq = 1'b0;
            m_id  = 4'd0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (chk_en) begin
            check("irq", int'(irq), int'(m_irq));
            check("irq_valid", int'(irq_valid), int'(m_irq));
            check("irq_id", int'(irq_id), int'(m_id));
            check("readdata", int'(readdata), int'(m_rd));
        end
    endtask

    task automatic idle();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick();
        idle();
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [15:0] v);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        tick();
        v = readdata;
        idle();
    endtask

    logic [15:0] v;

    initial begin
        reset = 1'b1;
        address = 3'd0;
        writedata = 16'd0;
        irq_in = '0;
        idle();
        tick();
        check("rst_irq", int'(irq), 0);
        check("rst_rd", int'(readdata), 0);
        reset = 1'b0;
        tick();

        // Level path
        bus_wr(3'd1, 16'h0001);
        bus_wr(3'd2, 16'h0000);
        irq_in[0] = 1'b1;
        tick(); tick(); tick();
        check("lvl_irq_k2", int'(irq), 0);
        tick();
        check("lvl_irq_k3", int'(irq), 1);
        check("lvl_id", int'(irq_id), 0);
        irq_in[0] = 1'b0;
        tick(); tick(); tick(); tick();
        check("lvl_drop", int'(irq), 0);
        bus_rd(3'd0, v);
        check("lvl_pend", int'(v), 16'h0000);

        // Edge capture and W1C
        bus_wr(3'd2, 16'h0004);
        bus_wr(3'd1, 16'h0004);
        irq_in[2] = 1'b1;
        tick();
        irq_in[2] = 1'b0;
        tick(); tick(); tick(); tick();
        bus_rd(3'd0, v);
        check("edge_pend", int'(v), 16'h0004);
        check("edge_irq", int'(irq), 1);
        bus_wr(3'd0, 16'h0004);
        bus_rd(3'd0, v);
        check("w1c_pend", int'(v), 16'h0000);
        check("w1c_irq", int'(irq), 0);
        bus_rd(3'd7, v);
        check("edge_evc", int'(v), 1);

        // Priority and mask
        bus_wr(3'd2, 16'h00FF);
        bus_wr(3'd1, 16'h00A0);
        bus_wr(3'd6, 16'h00E0);
        tick();
        bus_rd(3'd5, v);
        check("vec_5", int'(v), 16'h8005);
        bus_wr(3'd0, 16'h0020);
        tick();
        bus_rd(3'd5, v);
        check("vec_7", int'(v), 16'h8007);
        bus_wr(3'd1, 16'h0000);
        tick();
        check("mask0_irq", int'(irq), 0);
        bus_rd(3'd0, v);
        check("mask0_pend", int'(v), 16'h00C0);

        // Simultaneous set and clear
        bus_wr(3'd6, 16'h0008);
        irq_in[3] = 1'b1;
        tick(); tick();
        bus_wr(3'd0, 16'h0008);
        bus_rd(3'd0, v);
        check("setclr_pend", int'(v), 16'h00C8);
        bus_rd(3'd7, v);
        check("setclr_evc", int'(v), 4);

        // Saturating counter
        chk_en = 1'b0;
        chipselect = 1'b1;
        write_n = 1'b0;
        address = 3'd6;
        writedata = 16'h0001;
        for (int i = 0; i < 65540; i++) tick();
        idle();
        chk_en = 1'b1;
        bus_rd(3'd7, v);
        check("evc_sat", int'(v), 16'hFFFF);
        irq_in[1] = 1'b1;
        tick(); tick();
        bus_wr(3'd7, 16'h0000);
        bus_rd(3'd7, v);
        check("evc_clr", int'(v), 0);

        // Reset mid-operation
        irq_in = '0;
        bus_wr(3'd1, 16'h00FF);
        for (int i = 0; i < 5; i++) bus_wr(3'd6, 16'h0010);
        tick(); tick(); tick();
        bus_rd(3'd7, v);
        check("pre_evc", int'(v), 5);
        check("pre_irq", int'(irq), 1);
        reset = 1'b1;
        chipselect = 1'b1;
        write_n = 1'b0;
        address = 3'd1;
        writedata = 16'h00FF;
        tick();
        reset = 1'b0;
        idle();
        check("mid_irq", int'(irq), 0);
        check("mid_valid", int'(irq_valid), 0);
        check("mid_id", int'(irq_id), 0);
        check("mid_rd", int'(readdata), 0);
        for (int a = 0; a < 8; a++) begin
            bus_rd(3'(a), v);
            check("mid_reg", int'(v), 0);
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) irq_in = N'($urandom);
            chipselect = $urandom_range(0, 1) == 1;
            write_n = $urandom_range(0, 2) != 0;
            address = 3'($urandom);
            writedata = 16'($urandom);
            tick();
        end
        reset = 1'b0;
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
